// File: rtl/graph_pkg.sv
// graph_pkg: shared types for the adjacency map.
//   node_t      - node index at the default node capacity (1024 nodes)
//   edge_addr_t - edge-array address at the default edge capacity (2048 edges)
//   state_e     - controller states of adjacency_map
package graph_pkg;

  localparam int unsigned NODE_W  = $clog2(1024);
  localparam int unsigned EADDR_W = $clog2(2048);

  typedef logic [NODE_W-1:0]  node_t;
  typedef logic [EADDR_W-1:0] edge_addr_t;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_BUILD,
    ST_IDLE,
    ST_FETCH,
    ST_PRESENT
  } state_e;

endpackage

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port and one synchronous read port.
//   clk          - clock, rising edge
//   we/waddr/wdata - write strobe, address, data
//   re/raddr     - read strobe and address; rdata valid the cycle after re
//   rdata        - registered read data (holds when re is low)
module sdp_ram #(
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned WIDTH      = 22,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/adjacency_map.sv
// adjacency_map: builds per-source linked lists of directed edges, then
// answers queries by streaming a node's out-edge destinations, most recently
// inserted first.
//   clk, rst_n            - clock (rising edge), async active-low reset
//   decoding_done         - level, edge delivery finished
//   edge_valid/src_node/dst_node - edge insert strobe and endpoints
//   init_done             - head table cleared, edges accepted
//   query_valid/query_ready/query_data - query handshake and node
//   reply_valid/reply_ready/reply_data/reply_last/reply_no_edges_found
//                         - reply beat stream
//   edge_cnt              - number of stored edges
//   overflow              - sticky, an edge was dropped at capacity
module adjacency_map
  import graph_pkg::*;
#(
  parameter int unsigned MAX_NODES  = 1024,
  parameter int unsigned MAX_EDGES  = 2048,
  parameter int unsigned NODE_WIDTH = $clog2(MAX_NODES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      decoding_done,
  input  logic                      edge_valid,
  input  logic [NODE_WIDTH-1:0]     src_node,
  input  logic [NODE_WIDTH-1:0]     dst_node,
  output logic                      init_done,
  output logic                      query_ready,
  input  logic                      query_valid,
  input  logic [NODE_WIDTH-1:0]     query_data,
  output logic                      reply_valid,
  input  logic                      reply_ready,
  output logic [NODE_WIDTH-1:0]     reply_data,
  output logic                      reply_last,
  output logic                      reply_no_edges_found,
  output logic [$clog2(MAX_EDGES):0] edge_cnt,
  output logic                      overflow
);

  localparam int unsigned EA_W  = $clog2(MAX_EDGES);
  localparam int unsigned CNT_W = EA_W + 1;
  localparam int unsigned RAM_W = NODE_WIDTH + EA_W + 1;
  localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(MAX_EDGES);
  localparam logic [NODE_WIDTH-1:0] LAST_NODE = NODE_WIDTH'(MAX_NODES - 1);

  state_e                 state_q, state_d;
  logic [NODE_WIDTH-1:0]  clr_idx_q, clr_idx_d;
  logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
  logic                   overflow_q, overflow_d;
  logic [EA_W-1:0]        cursor_q, cursor_d;
  logic [NODE_WIDTH-1:0]  reply_data_q, reply_data_d;
  logic                   reply_last_q, reply_last_d;
  logic                   reply_none_q, reply_none_d;

  // Head table entry: {valid, edge address}, read combinationally.
  logic [EA_W:0]          head_q [MAX_NODES];
  logic                   head_we;
  logic [NODE_WIDTH-1:0]  head_waddr;
  logic [EA_W:0]          head_wdata;
  logic [EA_W:0]          head_src;
  logic [EA_W:0]          head_qry;

  // Edge RAM word: {dst, next_valid, next_addr}.
  logic                   ram_we;
  logic [EA_W-1:0]        ram_waddr;
  logic [RAM_W-1:0]       ram_wdata;
  logic                   ram_re;
  logic [EA_W-1:0]        ram_raddr;
  logic [RAM_W-1:0]       ram_rdata;

  assign head_src = head_q[src_node];
  assign head_qry = head_q[query_data];

  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    edge_cnt_d   = edge_cnt_q;
    overflow_d   = overflow_q;
    cursor_d     = cursor_q;
    reply_data_d = reply_data_q;
    reply_last_d = reply_last_q;
    reply_none_d = reply_none_q;
    head_we      = 1'b0;
    head_waddr   = src_node;
    head_wdata   = '0;
    ram_we       = 1'b0;
    ram_waddr    = edge_cnt_q[EA_W-1:0];
    ram_wdata    = {dst_node, head_src};
    ram_re       = 1'b0;
    ram_raddr    = cursor_q;

    unique case (state_q)
      ST_CLEAR: begin
        head_we    = 1'b1;
        head_waddr = clr_idx_q;
        head_wdata = '0;
        clr_idx_d  = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_NODE) begin
          state_d = ST_BUILD;
        end
      end
      ST_BUILD: begin
        // An edge in the same cycle as decoding_done is stored first; the
        // move to IDLE waits for a cycle without edge_valid.
        if (edge_valid) begin
          if (edge_cnt_q != CNT_FULL) begin
            ram_we     = 1'b1;
            head_we    = 1'b1;
            head_waddr = src_node;
            head_wdata = {1'b1, edge_cnt_q[EA_W-1:0]};
            edge_cnt_d = edge_cnt_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end else if (decoding_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (query_valid) begin
          if (!head_qry[EA_W]) begin
            reply_data_d = '0;
            reply_last_d = 1'b1;
            reply_none_d = 1'b1;
            state_d      = ST_PRESENT;
          end else begin
            // Launch the first RAM read now so FETCH sees the data.
            ram_re    = 1'b1;
            ram_raddr = head_qry[EA_W-1:0];
            state_d   = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        reply_data_d = ram_rdata[RAM_W-1 -: NODE_WIDTH];
        reply_last_d = !ram_rdata[EA_W];
        reply_none_d = 1'b0;
        cursor_d     = ram_rdata[EA_W-1:0];
        state_d      = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (reply_ready) begin
          if (reply_last_q) begin
            state_d = ST_IDLE;
          end else begin
            ram_re    = 1'b1;
            ram_raddr = cursor_q;
            state_d   = ST_FETCH;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CLEAR;
      clr_idx_q    <= '0;
      edge_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      cursor_q     <= '0;
      reply_data_q <= '0;
      reply_last_q <= 1'b0;
      reply_none_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      edge_cnt_q   <= edge_cnt_d;
      overflow_q   <= overflow_d;
      cursor_q     <= cursor_d;
      reply_data_q <= reply_data_d;
      reply_last_q <= reply_last_d;
      reply_none_q <= reply_none_d;
    end
  end

  // Head table has no reset; the CLEAR sweep invalidates every entry.
  always_ff @(posedge clk) begin
    if (head_we) begin
      head_q[head_waddr] <= head_wdata;
    end
  end

  sdp_ram #(
    .DEPTH(MAX_EDGES),
    .WIDTH(RAM_W)
  ) u_edge_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  assign init_done            = (state_q != ST_CLEAR);
  assign query_ready          = (state_q == ST_IDLE);
  assign reply_valid          = (state_q == ST_PRESENT);
  assign reply_data           = reply_data_q;
  assign reply_last           = reply_last_q;
  assign reply_no_edges_found = reply_none_q;
  assign edge_cnt             = edge_cnt_q;
  assign overflow             = overflow_q;

endmodule
